pc_fetch_unit: RTL

Instruction-fetch stage that owns the program-counter register and sits directly upstream of the PC incrementer.
- Drives the current PC to the incrementer and takes back the incremented value.
- Issues word-addressed instruction-memory requests over a req/ack handshake.
- Delivers fetched instructions into the IF/ID pipeline register.
- Handles downstream stall (one-entry skid buffer) and branch redirect (flush, plus draining of an in-flight request).

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/fetch_skid_buffer.sv | 34 +++
 rtl/pc_fetch_unit.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_pkg;

   localparam int          XLEN_DEFAULT     = 32;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   // Fetch controller states: idle, request outstanding, entry parked in skid,
   // and draining a request whose result must be thrown away after a redirect.
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_BUSY  = 2'd1,
      S_HOLD  = 2'd2,
      S_DRAIN = 2'd3
   } fetch_state_t;

   typedef struct packed {
      logic [XLEN_DEFAULT-1:0] pc;
      logic [XLEN_DEFAULT-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding register for a fetched {pc, instr} that ID could not take.
// Latency: loaded value visible one cycle after load; unload/clear empty it on the next edge.
// Backpressure: none internally; the owner only loads when empty and unloads when ID frees up.
module fetch_skid_buffer
   import fetch_pkg::*;
#(
   parameter type entry_t = fetch_entry_t
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   load,
   input  logic   unload,
   input  logic   clear,
   input  entry_t load_dat,
   output entry_t dat,
   output logic   full
);

   // Clear (flush) wins over load, load wins over unload.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full <= 1'b0;
         dat  <= '0;
      end else if (clear) begin
         full <= 1'b0;
      end else if (load) begin
         full <= 1'b1;
         dat  <= load_dat;
      end else if (unload) begin
         full <= 1'b0;
      end
   end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch stage: owns the PC, issues imem requests, fills the IF/ID register.
// Latency: first IF/ID entry two cycles after reset release with a zero-wait memory; then one per cycle.
// Backpressure: ID stall parks one returned word in a skid entry and stops issuing until ID drains it.
module pc_fetch_unit
   import fetch_pkg::*;
#(
   parameter int              XLEN     = XLEN_DEFAULT,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic [XLEN-1:0] pc_out,
   input  logic [XLEN-1:0] pc_incremented,
   input  logic            branch_taken,
   input  logic [XLEN-1:0] branch_target,
   input  logic            stall,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [XLEN-1:0] imem_rdata,
   output logic            ifid_valid,
   output logic [XLEN-1:0] ifid_pc,
   output logic [XLEN-1:0] ifid_instr
);

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } entry_t;

   fetch_state_t    state, state_nxt;
   logic [XLEN-1:0] pc, pc_nxt;
   logic            req_nxt;
   logic [XLEN-1:0] addr_nxt;
   logic            ifid_valid_nxt;
   logic [XLEN-1:0] ifid_pc_nxt, ifid_instr_nxt;

   logic            skid_load, skid_unload, skid_clear, skid_full;
   entry_t          skid_in, skid_dat;
   logic            slot_free;

   assign pc_out    = pc;
   assign slot_free = !ifid_valid || !stall;
   assign skid_in   = '{pc: imem_addr, instr: imem_rdata};

   fetch_skid_buffer #(.entry_t(entry_t)) u_skid (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (skid_load),
      .unload   (skid_unload),
      .clear    (skid_clear),
      .load_dat (skid_in),
      .dat      (skid_dat),
      .full     (skid_full)
   );

   // State and all registered outputs; reset clears everything immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         pc         <= RESET_PC;
         imem_req   <= 1'b0;
         imem_addr  <= '0;
         ifid_valid <= 1'b0;
         ifid_pc    <= '0;
         ifid_instr <= '0;
      end else begin
         state      <= state_nxt;
         pc         <= pc_nxt;
         imem_req   <= req_nxt;
         imem_addr  <= addr_nxt;
         ifid_valid <= ifid_valid_nxt;
         ifid_pc    <= ifid_pc_nxt;
         ifid_instr <= ifid_instr_nxt;
      end
   end

   // Next-state and next-output decode; a redirect pre-empts any launch or IF/ID write.
   always_comb begin
      state_nxt      = state;
      pc_nxt         = pc;
      req_nxt        = imem_req;
      addr_nxt       = imem_addr;
      // An entry taken by ID this cycle disappears unless something refills the slot.
      ifid_valid_nxt = ifid_valid && stall;
      ifid_pc_nxt    = ifid_pc;
      ifid_instr_nxt = ifid_instr;
      skid_load      = 1'b0;
      skid_unload    = 1'b0;
      skid_clear     = 1'b0;

      if (branch_taken) begin
         pc_nxt         = branch_target;
         ifid_valid_nxt = 1'b0;
         skid_clear     = 1'b1;
         case (state)
            S_IDLE:  state_nxt = S_IDLE;
            S_HOLD:  state_nxt = S_IDLE;
            S_BUSY, S_DRAIN: begin
               // The outstanding request must still complete; its data is dropped.
               if (imem_ack) begin
                  req_nxt   = 1'b0;
                  state_nxt = S_IDLE;
               end else begin
                  state_nxt = S_DRAIN;
               end
            end
            default: state_nxt = S_IDLE;
         endcase
      end else begin
         case (state)
            S_IDLE: begin
               req_nxt   = 1'b1;
               addr_nxt  = pc;
               pc_nxt    = pc_incremented;
               state_nxt = S_BUSY;
            end
            S_BUSY: begin
               if (imem_ack) begin
                  if (slot_free) begin
                     ifid_valid_nxt = 1'b1;
                     ifid_pc_nxt    = imem_addr;
                     ifid_instr_nxt = imem_rdata;
                     req_nxt        = 1'b1;
                     addr_nxt       = pc;
                     pc_nxt         = pc_incremented;
                  end else begin
                     skid_load = 1'b1;
                     req_nxt   = 1'b0;
                     state_nxt = S_HOLD;
                  end
               end
            end
            S_HOLD: begin
               if (!stall && skid_full) begin
                  skid_unload    = 1'b1;
                  ifid_valid_nxt = 1'b1;
                  ifid_pc_nxt    = skid_dat.pc;
                  ifid_instr_nxt = skid_dat.instr;
                  req_nxt        = 1'b1;
                  addr_nxt       = pc;
                  pc_nxt         = pc_incremented;
                  state_nxt      = S_BUSY;
               end
            end
            S_DRAIN: begin
               if (imem_ack) begin
                  req_nxt   = 1'b0;
                  state_nxt = S_IDLE;
               end
            end
            default: state_nxt = S_IDLE;
         endcase
      end
   end

endmodule
